pkt_tx_drain: RTL and testbench
===============================

Name: pkt_tx_drain

Overview:
- Transmit-side counterpart to the packet-receive path. It reads a stored packet from the pipeline's packet buffer memory, one word per address, between a host-supplied head and tail address.
- It emits the words on the standard 64-bit data/ctrl output stream with out_wr/out_rdy flow control.
- It sits between the Pipeline_demo buffer read port and the next module in the user data path. It is kicked off by the control FSM when the pipeline enters send mode.

Parameters:
- DATA_WIDTH, 64, stream data width.
- CTRL_WIDTH, DATA_WIDTH/8, stream ctrl width.
- ADDR_WIDTH, 8, buffer memory address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin draining head_addr..tail_addr.
- head_addr  in  ADDR_WIDTH  first word address; sampled on accepted start.
- tail_addr  in  ADDR_WIDTH  last word address, inclusive; sampled on accepted start.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  ADDR_WIDTH  buffer read address.
- mem_rd_data  in  DATA_WIDTH+CTRL_WIDTH  {ctrl,data}; valid exactly 1 cycle after mem_rd_en.
- out_data  out  DATA_WIDTH  stream data.
- out_ctrl  out  CTRL_WIDTH  stream ctrl.
- out_wr  out  1  stream write strobe.
- out_rdy  in  1  downstream can accept a word this cycle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word is written.
- pkt_count  out  32  packets fully sent since reset; wraps at 2^32.

Behaviour:
- Reset (reset=0, async) forces every output low/zero: out_data, out_ctrl, out_wr, mem_rd_en, mem_rd_addr, busy, done, pkt_count. The FSM returns to IDLE. Reset mid-packet abandons the packet with no done pulse and no pkt_count increment.
- States: IDLE, READ, LATCH, SEND, DONE.
- IDLE:
  - start=1 latches head/tail, sets cur_addr=head_addr, sets busy=1, and moves to READ.
  - start while busy is ignored.
- READ:
  - mem_rd_en=1 and mem_rd_addr=cur_addr for exactly one cycle; next state is LATCH.
  - mem_rd_en is 0 in every other state. mem_rd_addr holds its last value.
- LATCH:
  - Capture mem_rd_data into the hold register: ctrl = upper CTRL_WIDTH bits, data = lower DATA_WIDTH bits.
  - Next state is SEND.
- SEND:
  - out_data/out_ctrl are driven from the hold register.
  - out_wr=1 only in a cycle where out_rdy=1; it is never asserted while out_rdy=0. out_wr is combinational on state and out_rdy.
  - If out_rdy=0, stay in SEND and hold the word stable.
  - On a write: if cur_addr==tail go to DONE; otherwise cur_addr=cur_addr+1 (mod 2^ADDR_WIDTH) and go to READ.
- DONE: done=1 for one cycle, pkt_count+1, busy=0, then IDLE. A start arriving in the DONE cycle is ignored.
- Word count per packet = ((tail-head) mod 2^ADDR_WIDTH)+1.
  - tail<head wraps through address 0.
  - head==tail sends exactly one word.
- Latency:
  - First mem_rd_en is 1 cycle after start.
  - First out_wr is at the earliest 3 cycles after start.
  - Minimum 3 cycles per word.
- Ctrl words pass through unmodified: module header 0xFF, payload 0x00, last word nonzero byte mask. The block neither checks nor generates ctrl.
- out_data/out_ctrl keep their last value outside SEND. Downstream qualifies them with out_wr only.

Test Plan:
- Single word, out_rdy=1: head=tail=0x10, mem[0x10]={0xFF,64'hA5}, start. Required: reads at 0x10 one cycle after start; exactly one out_wr with data 64'hA5/ctrl 0xFF; done one cycle after it; pkt_count=1.
- Multi-word, out_rdy=1: head=0x00, tail=0x03, ctrl 0xFF,0x00,0x00,0x01. Required: 4 out_wr pulses in address order, spaced 3 cycles apart; done after the 4th; busy high throughout.
- Backpressure: same packet, hold out_rdy=0 for 5 cycles during word 2. Required: no out_wr while out_rdy=0; word 2 held stable; all 4 words delivered once, no duplicates or drops.
- Wrap-around: head=0xFE, tail=0x01. Required: reads 0xFE,0xFF,0x00,0x01; 4 words emitted.
- Start while busy, then back-to-back packets: start during word 1 is ignored; a second start after done sends the second packet; pkt_count=2.
- Reset mid-packet: assert reset at word 2 of 4. Required: all outputs 0 immediately (async), no done, pkt_count=0; a new start after reset release works normally.

Source files
------------

// File: rtl/pkt_tx_drain.sv
// pkt_tx_drain: drains a stored packet from buffer memory onto the 64-bit data/ctrl stream
module pkt_tx_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            head_addr,
    input  logic [ADDR_WIDTH-1:0]            tail_addr,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      pkt_count
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] tail;
    logic last;
    // the read address register doubles as the current word pointer; it only moves on entry to READ
    assign last = mem_rd_addr == tail;
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // next state and per-state strobes; out_wr follows out_rdy combinationally in SEND
    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        out_wr    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  state_nx = start ? READ : IDLE;
            READ: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                state_nx  = LATCH;
            end
            LATCH: begin
                busy     = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                busy     = 1'b1;
                out_wr   = out_rdy;
                state_nx = !out_rdy ? SEND : last ? DONE : READ;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // address pointer, word hold register (drives the stream directly) and packet counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd_addr <= '0;
            tail        <= '0;
            out_data    <= '0;
            out_ctrl    <= '0;
            pkt_count   <= '0;
        end else begin
            if (state == IDLE && start) begin
                mem_rd_addr <= head_addr;
                tail        <= tail_addr;
            end else if (out_wr && !last) begin
                mem_rd_addr <= mem_rd_addr + 1'b1;
            end
            if (state == LATCH) {out_ctrl, out_data} <= mem_rd_data;
            if (done) pkt_count <= pkt_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_pkt_tx_drain.sv
// tb_pkt_tx_drain: directed bench with a packet-level scoreboard model of the drain block
module tb_pkt_tx_drain;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        out_rdy = 1'b1;
    logic [7:0]  head_addr = '0;
    logic [7:0]  tail_addr = '0;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [71:0] mem_rd_data = '0;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr, busy, done;
    logic [31:0] pkt_count;
    logic [71:0] mem [256];
    int passed = 0;
    int total = 0;
    int cyc = 0;
    int done_seen = 0;
    int exp_cnt = 0;
    bit prev_done = 0;
    logic [71:0] exp_words[$];
    logic [7:0]  exp_reads[$];
    int wr_cycles[$];

    pkt_tx_drain dut (
        .clk(clk), .reset(reset), .start(start), .head_addr(head_addr), .tail_addr(tail_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // buffer memory: registered read, data valid the cycle after the strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // scoreboard: every read and write must match the next expected address/word in order
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", {out_wr, mem_rd_en, busy, done, mem_rd_addr, out_ctrl, out_data, pkt_count}, '0);
            exp_words.delete();
            exp_reads.delete();
            exp_cnt = 0;
            prev_done = 0;
        end else begin
            if (prev_done) exp_cnt++;
            prev_done = done;
            if (mem_rd_en) begin
                if (exp_reads.size() == 0) chk("rd_unexpected", mem_rd_addr, 128'h100);
                else chk("rd_addr", mem_rd_addr, exp_reads.pop_front());
            end
            if (out_wr) begin
                chk("wr_needs_rdy", out_rdy, 1);
                chk("busy_on_wr", busy, 1);
                wr_cycles.push_back(cyc);
                if (exp_words.size() == 0) chk("wr_unexpected", {out_ctrl, out_data}, 128'h1 << 72);
                else chk("wr_word", {out_ctrl, out_data}, exp_words.pop_front());
            end
            if (done) begin
                done_seen++;
                chk("done_all_sent", exp_words.size(), 0);
                chk("done_not_busy", busy, 0);
            end
            chk("pkt_count", pkt_count, exp_cnt);
        end
    end

    task automatic do_start(input logic [7:0] h, input logic [7:0] t, input bit accept);
        int n;
        @(posedge clk); #1;
        start = 1'b1; head_addr = h; tail_addr = t;
        n = int'(8'(t - h)) + 1;
        if (accept)
            for (int i = 0; i < n; i++) begin
                exp_reads.push_back(h + 8'(i));
                exp_words.push_back(mem[h + 8'(i)]);
            end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < 300 && done_seen == d0; i++) @(posedge clk);
        chk({name, "_done_seen"}, 128'(done_seen > d0), 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        for (int i = 0; i < 256; i++) mem[i] = {8'h00, 64'h1000 + 64'(i)};
        mem[8'h10] = {8'hFF, 64'hA5};
        mem[8'h00] = {8'hFF, 64'h0000_0000_0000_0100};
        mem[8'h01] = {8'h00, 64'h1111_2222_3333_4444};
        mem[8'h02] = {8'h00, 64'h5555_6666_7777_8888};
        mem[8'h03] = {8'h01, 64'h9999_AAAA_BBBB_CCCC};
        mem[8'hFE] = {8'hFF, 64'hFEFE_0000_0000_0001};
        mem[8'hFF] = {8'h00, 64'hFFFF_0000_0000_0002};
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // single word
        do_start(8'h10, 8'h10, 1);
        chk("t1_rd_en", mem_rd_en, 1);
        chk("t1_rd_addr", mem_rd_addr, 8'h10);
        chk("t1_busy", busy, 1);
        @(posedge clk); #1;
        chk("t1_no_wr_latch", out_wr, 0);
        @(posedge clk); #1;
        chk("t1_wr", out_wr, 1);
        chk("t1_data", out_data, 64'hA5);
        chk("t1_ctrl", out_ctrl, 8'hFF);
        @(posedge clk); #1;
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_pkt_count", pkt_count, 1);

        // multi-word, full rate
        n0 = wr_cycles.size();
        do_start(8'h00, 8'h03, 1);
        wait_done("t2");
        chk("t2_words", wr_cycles.size() - n0, 4);
        for (int i = n0 + 1; i < wr_cycles.size(); i++)
            chk("t2_spacing", wr_cycles[i] - wr_cycles[i-1], 3);

        // backpressure during word 2
        n0 = wr_cycles.size();
        do_start(8'h00, 8'h03, 1);
        repeat (4) @(posedge clk);
        #1 out_rdy = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("t3_no_wr", out_wr, 0);
            chk("t3_hold_data", out_data, 64'h1111_2222_3333_4444);
            chk("t3_hold_ctrl", out_ctrl, 8'h00);
        end
        out_rdy = 1'b1;
        wait_done("t3");
        chk("t3_words", wr_cycles.size() - n0, 4);

        // wrap through address 0
        n0 = wr_cycles.size();
        do_start(8'hFE, 8'h01, 1);
        wait_done("t4");
        chk("t4_words", wr_cycles.size() - n0, 4);
        chk("t4_reads_drained", exp_reads.size(), 0);

        // start while busy, start during DONE, then back-to-back packets
        pulse_reset();
        do_start(8'h20, 8'h22, 1);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; head_addr = 8'h50; tail_addr = 8'h50;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_still_busy", busy, 1);
        for (int i = 0; i < 50 && done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_done_found", done, 1);
        start = 1'b1; head_addr = 8'h60; tail_addr = 8'h60;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_done_start_busy", busy, 0);
        chk("t5_done_start_rd", mem_rd_en, 0);
        do_start(8'h30, 8'h30, 1);
        wait_done("t5");
        chk("t5_pkt_count", pkt_count, 2);

        // reset in the middle of a packet
        pulse_reset();
        do_start(8'h00, 8'h03, 1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_outputs", {out_wr, mem_rd_en, busy, done, mem_rd_addr, out_ctrl, out_data, pkt_count}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_done", done, 0);
        chk("t6_pkt_count_zero", pkt_count, 0);
        do_start(8'h02, 8'h03, 1);
        wait_done("t6");
        chk("t6_pkt_count_one", pkt_count, 1);
        chk("final_words_drained", exp_words.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
